// File: rtl/pe_pkg.sv
// Shared definitions for the next-generation GNN processing element.
// FSM encoding plus width and saturation helpers.
package pe_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic signed [63:0] saturate(
    input logic signed [63:0] v,
    input int                 w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pe_top_gen_if.sv
// Feature-input and result-output handshake bundle of the PE.
// slave is the PE side; master is the producer/consumer side.
interface pe_top_gen_if #(
  parameter int MAC_DIM      = 5,
  parameter int FEAT_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 6,
  parameter int NZ_CNT_WIDTH = 3,
  parameter int TAG_WIDTH    = 5,
  parameter int PE_OUT_WIDTH = 16
);

  logic                          x_valid;
  logic                          x_ready;
  logic [MAC_DIM*FEAT_WIDTH-1:0] x_data;
  logic [MAC_DIM*ADDR_WIDTH-1:0] x_addr;
  logic [NZ_CNT_WIDTH-1:0]       x_nz;
  logic                          x_acc;
  logic                          x_done;
  logic [TAG_WIDTH-1:0]          x_tag;
  logic                          out_valid;
  logic                          out_ready;
  logic [PE_OUT_WIDTH-1:0]       out_data;
  logic [TAG_WIDTH-1:0]          out_tag;

  modport master (
    output x_valid, x_data, x_addr, x_nz,
    output x_acc, x_done, x_tag, out_ready,
    input  x_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  x_valid, x_data, x_addr, x_nz,
    input  x_acc, x_done, x_tag, out_ready,
    output x_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/pe_mac_lanes.sv
// Combinational multi-lane MAC: masked lane products summed into
// the running accumulator with signed saturation.
module pe_mac_lanes
  import pe_pkg::*;
#(
  parameter int MAC_DIM      = 5,
  parameter int FEAT_WIDTH   = 1,
  parameter int WGT_WIDTH    = 8,
  parameter int PE_OUT_WIDTH = 16,
  parameter int NZ_CNT_WIDTH = 3
) (
  input  logic [MAC_DIM*FEAT_WIDTH-1:0] feat_i,
  input  logic [MAC_DIM*WGT_WIDTH-1:0]  wgt_i,
  input  logic [NZ_CNT_WIDTH-1:0]       nz_i,
  input  logic                          acc_en_i,
  input  logic signed [PE_OUT_WIDTH-1:0] acc_i,
  output logic signed [PE_OUT_WIDTH-1:0] acc_o
);

  localparam int PW = WGT_WIDTH + FEAT_WIDTH + 1;

  logic signed [PW-1:0] fe;
  logic signed [PW-1:0] we;
  logic signed [PW-1:0] p;
  logic signed [63:0]   sum;
  logic signed [63:0]   tot;

  // lanes at or beyond nz are masked, so nz > MAC_DIM saturates naturally
  always_comb begin
    fe  = '0;
    we  = '0;
    p   = '0;
    sum = '0;
    for (int j = 0; j < MAC_DIM; j++) begin
      fe = PW'($signed({1'b0, feat_i[j*FEAT_WIDTH +: FEAT_WIDTH]}));
      we = PW'($signed(wgt_i[j*WGT_WIDTH +: WGT_WIDTH]));
      p  = fe * we;
      if (j < int'(nz_i)) sum = sum + 64'(p);
    end
    tot   = acc_en_i ? 64'(acc_i) + sum : sum;
    acc_o = PE_OUT_WIDTH'(saturate(tot, PE_OUT_WIDTH));
  end

endmodule

// File: rtl/pe_top_gen.sv
// GNN PE wrapper: double-buffered weight scratchpad, handshaked
// feature beats, saturating multi-lane MAC and tagged results.
module pe_top_gen
  import pe_pkg::*;
#(
  parameter int MAC_DIM      = 5,
  parameter int FEAT_WIDTH   = 1,
  parameter int WGT_WIDTH    = 8,
  parameter int SPAD_DEPTH   = 64,
  parameter int BUS_WIDTH    = 64,
  parameter int PE_OUT_WIDTH = 16,
  parameter int TAG_WIDTH    = 5,
  parameter int ADDR_WIDTH   = clog2(SPAD_DEPTH),
  parameter int WPB          = BUS_WIDTH / WGT_WIDTH,
  parameter int ROW_WIDTH    = clog2(SPAD_DEPTH / WPB),
  parameter int NZ_CNT_WIDTH = clog2(MAC_DIM + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 w_we,
  input  logic [ROW_WIDTH-1:0] w_row,
  input  logic [BUS_WIDTH-1:0] w_data,
  input  logic                 w_swap,
  pe_top_gen_if.slave          pe,
  output logic                 active_bank,
  output logic                 busy
);

  logic [WGT_WIDTH-1:0] mem_q [2][SPAD_DEPTH];

  logic [1:0] state_q, state_d;
  logic       bank_q, bank_d;
  logic       pend_q, pend_d;
  logic       ovalid_q, ovalid_d;

  logic signed [PE_OUT_WIDTH-1:0] acc_q, acc_d;
  logic signed [PE_OUT_WIDTH-1:0] mac_acc;
  logic [PE_OUT_WIDTH-1:0]        odata_q, odata_d;
  logic [TAG_WIDTH-1:0]           otag_q, otag_d;

  logic [MAC_DIM*FEAT_WIDTH-1:0] feat_q, feat_d;
  logic [MAC_DIM*ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [NZ_CNT_WIDTH-1:0]       nz_q, nz_d;
  logic                          accen_q, accen_d;
  logic                          done_q, done_d;
  logic [TAG_WIDTH-1:0]          tag_q, tag_d;

  logic [MAC_DIM*WGT_WIDTH-1:0] wgt_bus;
  logic idle, swap_go, accept;

  // a pending swap takes the idle cycle, so no beat can straddle it
  assign idle        = (state_q == S_IDLE);
  assign swap_go     = idle & pend_q;
  assign pe.x_ready  = idle & ~pend_q;
  assign accept      = pe.x_valid & pe.x_ready;
  assign busy        = ~idle;
  assign active_bank = bank_q;
  assign pe.out_valid = ovalid_q;
  assign pe.out_data  = odata_q;
  assign pe.out_tag   = otag_q;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int k = 0; k < WPB; k++) begin
        mem_q[~bank_q][ADDR_WIDTH'(int'(w_row) * WPB + k)] <=
          w_data[k*WGT_WIDTH +: WGT_WIDTH];
      end
    end
  end

  always_comb begin
    wgt_bus = '0;
    for (int j = 0; j < MAC_DIM; j++) begin
      wgt_bus[j*WGT_WIDTH +: WGT_WIDTH] =
        mem_q[bank_q][addr_q[j*ADDR_WIDTH +: ADDR_WIDTH]];
    end
  end

  pe_mac_lanes #(
    .MAC_DIM      (MAC_DIM),
    .FEAT_WIDTH   (FEAT_WIDTH),
    .WGT_WIDTH    (WGT_WIDTH),
    .PE_OUT_WIDTH (PE_OUT_WIDTH),
    .NZ_CNT_WIDTH (NZ_CNT_WIDTH)
  ) u_lanes (
    .feat_i   (feat_q),
    .wgt_i    (wgt_bus),
    .nz_i     (nz_q),
    .acc_en_i (accen_q),
    .acc_i    (acc_q),
    .acc_o    (mac_acc)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    otag_d   = otag_q;
    bank_d   = bank_q ^ swap_go;
    pend_d   = swap_go ? 1'b0 : (pend_q | w_swap);
    feat_d   = feat_q;
    addr_d   = addr_q;
    nz_d     = nz_q;
    accen_d  = accen_q;
    done_d   = done_q;
    tag_d    = tag_q;
    if (accept) begin
      feat_d  = pe.x_data;
      addr_d  = pe.x_addr;
      nz_d    = pe.x_nz;
      accen_d = pe.x_acc;
      done_d  = pe.x_done;
      tag_d   = pe.x_tag;
    end
    unique case (1'b1)
      idle: begin
        if (accept) state_d = S_MAC;
      end
      state_q == S_MAC: begin
        acc_d = mac_acc;
        if (done_q) begin
          ovalid_d = 1'b1;
          odata_d  = mac_acc;
          otag_d   = tag_q;
          state_d  = S_OUT;
        end else begin
          state_d = S_IDLE;
        end
      end
      state_q == S_OUT: begin
        if (pe.out_ready) begin
          ovalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bank_q   <= 1'b0;
      pend_q   <= 1'b0;
      ovalid_q <= 1'b0;
      acc_q    <= '0;
      odata_q  <= '0;
      otag_q   <= '0;
      feat_q   <= '0;
      addr_q   <= '0;
      nz_q     <= '0;
      accen_q  <= 1'b0;
      done_q   <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      pend_q   <= pend_d;
      ovalid_q <= ovalid_d;
      acc_q    <= acc_d;
      odata_q  <= odata_d;
      otag_q   <= otag_d;
      feat_q   <= feat_d;
      addr_q   <= addr_d;
      nz_q     <= nz_d;
      accen_q  <= accen_d;
      done_q   <= done_d;
      tag_q    <= tag_d;
    end
  end

endmodule

// File: tb/tb_pe_top_gen.sv
// Bench for pe_top_gen: directed scenarios plus a randomized phase,
// all checked every cycle against a transaction-level model.
module tb_pe_top_gen;

  localparam int MD  = 5;
  localparam int FW  = 1;
  localparam int WW  = 8;
  localparam int SD  = 64;
  localparam int BW  = 64;
  localparam int OW  = 16;
  localparam int TW  = 5;
  localparam int AW  = 6;
  localparam int WPB = 8;
  localparam int RW  = 3;
  localparam int NW  = 3;
  localparam int HI  = (1 << (OW - 1)) - 1;
  localparam int LO  = -(1 << (OW - 1));

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          w_we = 1'b0;
  logic          w_swap = 1'b0;
  logic [RW-1:0] w_row = '0;
  logic [BW-1:0] w_data = '0;
  logic          active_bank;
  logic          busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  pe_top_gen_if #(
    .MAC_DIM(MD), .FEAT_WIDTH(FW), .ADDR_WIDTH(AW),
    .NZ_CNT_WIDTH(NW), .TAG_WIDTH(TW), .PE_OUT_WIDTH(OW)
  ) bus ();

  pe_top_gen #(
    .MAC_DIM(MD), .FEAT_WIDTH(FW), .WGT_WIDTH(WW),
    .SPAD_DEPTH(SD), .BUS_WIDTH(BW), .PE_OUT_WIDTH(OW),
    .TAG_WIDTH(TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .w_we        (w_we),
    .w_row       (w_row),
    .w_data      (w_data),
    .w_swap      (w_swap),
    .pe          (bus),
    .active_bank (active_bank),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // model state: banks, swap flag, accumulator, beat in flight, result
  logic signed [WW-1:0] wmem [2][SD];
  bit m_bank, m_pend, m_mac, m_out, e_valid, p_done;
  int m_acc, p_acc, e_data;
  logic [TW-1:0] p_tag, e_tag;

  function automatic void chk(input string nm,
                              input logic signed [31:0] act,
                              input logic signed [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int sat(input int v);
    if (v > HI) return HI;
    if (v < LO) return LO;
    return v;
  endfunction

  function automatic int lane_sum(input bit b,
                                  input logic [MD*FW-1:0] d,
                                  input logic [MD*AW-1:0] a,
                                  input logic [NW-1:0] nz);
    int s = 0;
    int n = (int'(nz) > MD) ? MD : int'(nz);
    for (int j = 0; j < n; j++)
      if (d[j]) s += int'(wmem[b][a[j*AW +: AW]]);
    return s;
  endfunction

  always @(posedge clk) begin : model
    bit idle, rdy, swp;
    int s;
    idle = !m_mac && !m_out;
    rdy  = idle && !m_pend;
    swp  = idle && m_pend;
    if (w_we)
      for (int k = 0; k < WPB; k++)
        wmem[!m_bank][int'(w_row) * WPB + k] = w_data[k*WW +: WW];
    if (reset) begin
      m_bank = 0; m_pend = 0; m_mac = 0; m_out = 0;
      m_acc = 0; e_valid = 0; e_data = 0; e_tag = '0;
    end else begin
      if (m_mac) begin
        m_acc = p_acc;
        m_mac = 0;
        if (p_done) begin
          e_valid = 1; e_data = p_acc; e_tag = p_tag; m_out = 1;
        end
      end else if (m_out && bus.out_ready) begin
        e_valid = 0; m_out = 0;
      end
      if (bus.x_valid && rdy) begin
        s = lane_sum(m_bank, bus.x_data, bus.x_addr, bus.x_nz);
        p_acc  = sat(bus.x_acc ? m_acc + s : s);
        p_done = bus.x_done;
        p_tag  = bus.x_tag;
        m_mac  = 1;
      end
      if (swp) begin
        m_bank = !m_bank; m_pend = 0;
      end else if (w_swap) begin
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("x_ready", bus.x_ready, !m_mac && !m_out && !m_pend);
      chk("busy", busy, m_mac || m_out);
      chk("active_bank", active_bank, m_bank);
      chk("out_valid", bus.out_valid, e_valid);
      if (e_valid) begin
        chk("out_data", $signed(bus.out_data), e_data);
        chk("out_tag", bus.out_tag, e_tag);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MD*AW-1:0] ad(input int a0, a1, a2, a3, a4);
    return {AW'(a4), AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [BW-1:0] rowv(input int base, input int step);
    logic [BW-1:0] r;
    for (int k = 0; k < WPB; k++) r[k*WW +: WW] = WW'(base + step * k);
    return r;
  endfunction

  task automatic load_row(input int row, input logic [BW-1:0] d);
    w_we = 1; w_row = RW'(row); w_data = d;
    tick();
    w_we = 0;
  endtask

  task automatic swap();
    w_swap = 1;
    tick();
    w_swap = 0;
    tick();
  endtask

  task automatic send(input logic [MD*FW-1:0] d, input logic [MD*AW-1:0] a,
                      input logic [NW-1:0] nz, input bit acc,
                      input bit done, input logic [TW-1:0] tag);
    bit ok = 0;
    bus.x_valid = 1; bus.x_data = d; bus.x_addr = a; bus.x_nz = nz;
    bus.x_acc = acc; bus.x_done = done; bus.x_tag = tag;
    for (int n = 0; n < 50 && !ok; n++) begin
      ok = bus.x_ready;
      tick();
    end
    bus.x_valid = 0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    if (!bus.out_valid) chk("out_timeout", 0, 1);
  endtask

  initial begin
    int n;
    bus.x_valid = 0; bus.x_data = '0; bus.x_addr = '0; bus.x_nz = '0;
    bus.x_acc = 0; bus.x_done = 0; bus.x_tag = '0; bus.out_ready = 1;
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_bank", active_bank, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x_ready", bus.x_ready, 1);

    // bank1 gets w[i]=i, then becomes active; bank0 gets random data
    for (int r = 0; r < SD / WPB; r++) load_row(r, rowv(r * WPB, 1));
    swap();
    chk("swap_idle_bank", active_bank, 1);
    for (int r = 0; r < SD / WPB; r++) load_row(r, {$urandom, $urandom});

    send(5'b11111, ad(1, 2, 3, 4, 5), 5, 0, 1, 7);
    wait_out(n);
    chk("lat_done", n, 1);
    chk("t1_data", $signed(bus.out_data), 15);
    chk("t1_tag", bus.out_tag, 7);
    tick();

    send(5'b11111, ad(0, 1, 2, 3, 4), 5, 0, 0, 1);
    chk("mac_x_ready", bus.x_ready, 0);
    chk("mac_busy", busy, 1);
    send(5'b11111, ad(0, 1, 2, 3, 4), 5, 1, 0, 1);
    send(5'b11111, ad(0, 1, 2, 3, 4), 5, 1, 1, 2);
    wait_out(n);
    chk("t2_data", $signed(bus.out_data), 30);
    tick();

    bus.out_ready = 0;
    send(5'b11111, ad(0, 1, 2, 3, 4), 5, 0, 1, 12);
    wait_out(n);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", $signed(bus.out_data), 10);
      chk("hold_tag", bus.out_tag, 12);
      chk("hold_ready", bus.x_ready, 0);
    end
    bus.out_ready = 1;
    tick();
    chk("rel_valid", bus.out_valid, 0);
    chk("rel_busy", busy, 0);

    load_row(0, rowv(127, 0));
    swap();
    chk("sat_bank0", active_bank, 0);
    for (int i = 0; i < 60; i++)
      send(5'b11111, ad(0, 0, 0, 0, 0), 5, i > 0, i == 59, 1);
    wait_out(n);
    chk("sat_pos", $signed(bus.out_data), HI);
    tick();
    load_row(0, rowv(-128, 0));
    swap();
    for (int i = 0; i < 60; i++)
      send(5'b11111, ad(0, 0, 0, 0, 0), 5, i > 0, i == 59, 2);
    wait_out(n);
    chk("sat_neg", $signed(bus.out_data), LO);
    tick();

    // swap and shadow write issued while the node is in flight
    bus.out_ready = 0;
    send(5'b11111, ad(8, 9, 10, 11, 12), 5, 0, 1, 3);
    w_we = 1; w_row = 1; w_data = '0; w_swap = 1;
    tick();
    w_we = 0; w_swap = 0;
    for (int i = 0; i < 3; i++) begin
      chk("busy_swap_bank", active_bank, 1);
      tick();
    end
    chk("old_bank_data", $signed(bus.out_data), 50);
    bus.out_ready = 1;
    tick();
    chk("swap_blocks_ready", bus.x_ready, 0);
    tick();
    chk("late_swap_bank", active_bank, 0);
    send(5'b11111, ad(8, 9, 10, 11, 12), 5, 0, 1, 4);
    wait_out(n);
    chk("shadow_write", $signed(bus.out_data), 0);
    tick();

    send(5'b11111, ad(0, 0, 0, 0, 0), 0, 0, 1, 5);
    wait_out(n);
    chk("nz0", $signed(bus.out_data), 0);
    tick();
    send(5'b11111, ad(0, 0, 0, 0, 0), 2, 0, 1, 5);
    wait_out(n);
    chk("nz2_mask", $signed(bus.out_data), 254);
    tick();
    send(5'b11111, ad(0, 0, 0, 0, 0), 7, 0, 1, 5);
    wait_out(n);
    chk("nz7_clamp", $signed(bus.out_data), 635);
    tick();

    send(5'b11111, ad(0, 0, 0, 0, 0), 5, 0, 1, 6);
    reset = 1;
    tick();
    reset = 0;
    chk("rst_mac_valid", bus.out_valid, 0);
    chk("rst_mac_busy", busy, 0);
    tick();
    chk("rst_mac_drop", bus.out_valid, 0);
    send(5'b00001, ad(0, 0, 0, 0, 0), 1, 1, 1, 9);
    wait_out(n);
    chk("rst_acc_zero", $signed(bus.out_data), 127);
    chk("rst_acc_tag", bus.out_tag, 9);
    tick();

    for (int c = 0; c < 3000; c++) begin
      reset         = ($urandom_range(0, 399) == 0);
      bus.x_valid   = $urandom_range(0, 1) == 1;
      bus.x_data    = (MD*FW)'($urandom);
      bus.x_addr    = (MD*AW)'($urandom);
      bus.x_nz      = NW'($urandom_range(0, 7));
      bus.x_acc     = $urandom_range(0, 3) != 0;
      bus.x_done    = $urandom_range(0, 2) == 0;
      bus.x_tag     = TW'($urandom);
      bus.out_ready = $urandom_range(0, 3) != 0;
      w_we          = $urandom_range(0, 4) == 0;
      w_row         = RW'($urandom);
      w_data        = {$urandom, $urandom};
      w_swap        = $urandom_range(0, 29) == 0;
      tick();
    end
    reset = 0; bus.x_valid = 0; w_we = 0; w_swap = 0; bus.out_ready = 1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
